// File: rtl/cpu_trace_monitor.sv
// -----------------------------------------------------------------------------
// cpu_trace_monitor
// Passive observer beside the cpu2 core. While armed (RUN) it builds one trace
// record per cycle from the core's fetch/decode/writeback signals and pushes it
// into a FIFO that a ready/valid consumer drains. It also counts captured
// instructions and detects a self-loop halt (pc unchanged for HALT_REPEAT
// consecutive cycles).
//
// Ports
//   clk, rst_n      core clock / asynchronous active-low reset
//   start           1-cycle pulse, arms capture from IDLE or HALTED
//   pc, instr       core program counter and instruction word this cycle
//   reg_waddr       regfile write address this cycle
//   reg_we, dm_we   regfile / data-memory write enables this cycle
//   trace_valid     FIFO head holds a record (registered)
//   trace_data      {seq[15:0], pc, instr, reg_waddr, reg_we, dm_we} (registered)
//   trace_ready     consumer accepts the head when trace_valid is high
//   instr_count     records captured since start, dropped ones included
//   drop_count      records lost to a full FIFO
//   overflow        sticky, set on the first drop
//   halted          sticky, set on halt detection
// -----------------------------------------------------------------------------
module cpu_trace_monitor #(
   parameter int DEPTH       = 16,
   parameter int HALT_REPEAT = 4,
   parameter int CNT_W       = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      pc,
   input  logic [31:0]      instr,
   input  logic [4:0]       reg_waddr,
   input  logic             reg_we,
   input  logic             dm_we,
   output logic             trace_valid,
   output logic [86:0]      trace_data,
   input  logic             trace_ready,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] drop_count,
   output logic             overflow,
   output logic             halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2(HALT_REPEAT) + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   localparam logic [AW:0]      PTR_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [RW-1:0]    RPT_ZERO = {RW{1'b0}};
   localparam logic [RW-1:0]    RPT_ONE  = {{(RW-1){1'b0}}, 1'b1};
   // rpt value that, after one more match, reaches HALT_REPEAT-1
   localparam logic [RW-1:0]    RPT_LAST = RW'(HALT_REPEAT - 2);

   logic [1:0]       state_q,    state_d;
   logic [AW:0]      wr_ptr_q,   wr_ptr_d;
   logic [AW:0]      rd_ptr_q,   rd_ptr_d;
   logic             head_vld_q, head_vld_d;
   logic [86:0]      head_dat_q, head_dat_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [CNT_W-1:0] drop_q,     drop_d;
   logic             ovf_q,      ovf_d;
   logic             halt_q,     halt_d;
   logic [RW-1:0]    rpt_q,      rpt_d;
   logic [31:0]      prev_pc_q,  prev_pc_d;
   logic             prev_vld_q, prev_vld_d;
   logic [86:0]      mem_q [DEPTH];

   logic        capture_s;
   logic        clear_s;
   logic        pop_s;
   logic        full_s;
   logic        push_s;
   logic        drop_s;
   logic        match_s;
   logic [86:0] record_s;

   assign capture_s = (state_q == ST_RUN);
   assign clear_s   = start & (state_q != ST_RUN);
   assign pop_s     = head_vld_q & trace_ready;
   assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // A full FIFO still accepts a record when the head leaves on the same edge
   assign push_s    = capture_s & (~full_s | pop_s);
   assign drop_s    = capture_s & full_s & ~pop_s;
   // prev_vld_q keeps the first RUN cycle from matching the cleared prev_pc
   assign match_s   = prev_vld_q & (pc == prev_pc_q);
   assign record_s  = {cnt_q[15:0], pc, instr, reg_waddr, reg_we, dm_we};

   // FIFO pointer and registered-head next state
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      head_dat_d = head_dat_q;
      if (clear_s) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
      head_vld_d = (wr_ptr_d != rd_ptr_d);
      // The new head is the record being written now when it lands in the
      // head slot; otherwise it is already in storage. With no head the
      // output keeps its last value.
      if (head_vld_d) begin
         if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_dat_d = record_s;
         end else begin
            head_dat_d = mem_q[rd_ptr_d[AW-1:0]];
         end
      end else begin
         head_dat_d = head_dat_q;
      end
   end

   // Control FSM, counters and halt detection next state
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drop_d     = drop_q;
      ovf_d      = ovf_q;
      halt_d     = halt_q;
      rpt_d      = rpt_q;
      prev_pc_d  = prev_pc_q;
      prev_vld_d = prev_vld_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               state_d    = ST_RUN;
               cnt_d      = CNT_ZERO;
               drop_d     = CNT_ZERO;
               ovf_d      = 1'b0;
               halt_d     = 1'b0;
               rpt_d      = RPT_ZERO;
               prev_pc_d  = 32'h0000_0000;
               prev_vld_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (&cnt_q) begin
               cnt_d = cnt_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
            if (drop_s) begin
               ovf_d = 1'b1;
               if (&drop_q) begin
                  drop_d = drop_q;
               end else begin
                  drop_d = drop_q + CNT_ONE;
               end
            end else begin
               drop_d = drop_q;
            end
            prev_pc_d  = pc;
            prev_vld_d = 1'b1;
            if (match_s) begin
               rpt_d = rpt_q + RPT_ONE;
               if (rpt_q == RPT_LAST) begin
                  state_d = ST_HALTED;
                  halt_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               rpt_d = RPT_ZERO;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         head_vld_q <= 1'b0;
         head_dat_q <= 87'd0;
         cnt_q      <= CNT_ZERO;
         drop_q     <= CNT_ZERO;
         ovf_q      <= 1'b0;
         halt_q     <= 1'b0;
         rpt_q      <= RPT_ZERO;
         prev_pc_q  <= 32'h0000_0000;
         prev_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         head_vld_q <= head_vld_d;
         head_dat_q <= head_dat_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
         ovf_q      <= ovf_d;
         halt_q     <= halt_d;
         rpt_q      <= rpt_d;
         prev_pc_q  <= prev_pc_d;
         prev_vld_q <= prev_vld_d;
      end
   end

   // FIFO storage; contents are only ever read behind a valid pointer
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= record_s;
      end
   end

   assign trace_valid = head_vld_q;
   assign trace_data  = head_dat_q;
   assign instr_count = cnt_q;
   assign drop_count  = drop_q;
   assign overflow    = ovf_q;
   assign halted      = halt_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_monitor
// Directed bench: the stimulus pushes each expected trace record into a
// scoreboard queue; an independent monitor pops and compares whenever the
// DUT hands a record to the consumer.
// -----------------------------------------------------------------------------
module tb_cpu_trace_monitor;

   localparam int DEPTH       = 16;
   localparam int HALT_REPEAT = 4;
   localparam int CNT_W       = 17;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [31:0]      pc;
   logic [31:0]      instr;
   logic [4:0]       reg_waddr;
   logic             reg_we;
   logic             dm_we;
   logic             trace_valid;
   logic [86:0]      trace_data;
   logic             trace_ready;
   logic [CNT_W-1:0] instr_count;
   logic [CNT_W-1:0] drop_count;
   logic             overflow;
   logic             halted;

   int          tests;
   int          fails;
   logic [86:0] sb_q [$];
   logic [86:0] last_rec;

   cpu_trace_monitor #(
      .DEPTH      (DEPTH),
      .HALT_REPEAT(HALT_REPEAT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .pc         (pc),
      .instr      (instr),
      .reg_waddr  (reg_waddr),
      .reg_we     (reg_we),
      .dm_we      (dm_we),
      .trace_valid(trace_valid),
      .trace_data (trace_data),
      .trace_ready(trace_ready),
      .instr_count(instr_count),
      .drop_count (drop_count),
      .overflow   (overflow),
      .halted     (halted)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] instr_of(input logic [31:0] p);
      return p ^ 32'hA5C3_0013;
   endfunction

   function automatic logic [86:0] mk_rec(input logic [15:0] s, input logic [31:0] p);
      return {s, p, instr_of(p), p[6:2], p[2], p[4]};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input logic [31:0] p);
      pc        = p;
      instr     = instr_of(p);
      reg_waddr = p[6:2];
      reg_we    = p[2];
      dm_we     = p[4];
   endtask

   // One core cycle; optionally registers the record the DUT should capture
   task automatic run_cyc(input logic [31:0] p, input bit exp_push, input logic [15:0] s);
      set_core(p);
      if (exp_push) sb_q.push_back(mk_rec(s, p));
      tick();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      trace_ready = 1'b1;
      while ((sb_q.size() != 0 || trace_valid) && n < 60) begin
         tick();
         n++;
      end
      check(name, {127'd0, (sb_q.size() == 0 && !trace_valid)}, 128'd1);
   endtask

   // Scoreboard monitor: compares every record accepted by the consumer
   initial begin
      logic [86:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n && trace_valid && trace_ready) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL rec_unexpected: got %0h expected none", trace_data);
            end else begin
               exp = sb_q.pop_front();
               last_rec = exp;
               if (trace_data !== exp) begin
                  fails++;
                  $display("FAIL rec: got %0h expected %0h", trace_data, exp);
               end
            end
         end
      end
   end

   // Directed stimulus
   initial begin
      tests = 0;
      fails = 0;
      last_rec = 87'd0;
      rst_n = 1'b0;
      start = 1'b0;
      trace_ready = 1'b1;
      set_core(32'h0000_0000);
      tick();
      tick();
      rst_n = 1'b1;

      // 1: no start -> nothing captured
      check("rst_valid", {127'd0, trace_valid}, 128'd0);
      check("rst_data", {41'd0, trace_data}, 128'd0);
      check("rst_ovf", {127'd0, overflow}, 128'd0);
      for (int i = 0; i < 10; i++) run_cyc(32'h40 + 32'(i * 8), 1'b0, 16'd0);
      check("idle_valid", {127'd0, trace_valid}, 128'd0);
      check("idle_cnt", {111'd0, instr_count}, 128'd0);
      check("idle_halt", {127'd0, halted}, 128'd0);

      // 2: four sequential records, then spin on pc 12 to halt
      do_start();
      for (int i = 0; i < 4; i++) run_cyc(32'(i * 4), 1'b1, 16'(i));
      check("t2_cnt4", {111'd0, instr_count}, 128'd4);
      for (int i = 4; i < 7; i++) run_cyc(32'd12, 1'b1, 16'(i));
      check("t2_halt", {127'd0, halted}, 128'd1);
      check("t2_cnt7", {111'd0, instr_count}, 128'd7);
      drain("t2_drain");
      check("t2_hold", {41'd0, trace_data}, {41'd0, mk_rec(16'd6, 32'd12)});

      // 3: fill with consumer stalled, three drops
      trace_ready = 1'b0;
      do_start();
      check("t3_restart_halt", {127'd0, halted}, 128'd0);
      for (int i = 0; i < DEPTH + 3; i++)
         run_cyc(32'h100 + 32'(i * 4), (i < DEPTH), 16'(i));
      check("t3_drop", {111'd0, drop_count}, 128'd3);
      check("t3_ovf", {127'd0, overflow}, 128'd1);
      check("t3_cnt", {111'd0, instr_count}, 128'd19);

      // 5: full FIFO with pop and push on the same edge -> no drop
      trace_ready = 1'b1;
      run_cyc(32'h200, 1'b1, 16'd19);
      trace_ready = 1'b0;
      check("t5_drop_same", {111'd0, drop_count}, 128'd3);
      // still full: the next capture must drop
      run_cyc(32'h204, 1'b0, 16'd20);
      check("t5_still_full", {111'd0, drop_count}, 128'd4);
      for (int i = 21; i < 24; i++) run_cyc(32'h204, 1'b0, 16'(i));
      check("t5_halt", {127'd0, halted}, 128'd1);
      check("t5_drop_end", {111'd0, drop_count}, 128'd7);
      check("t5_cnt", {111'd0, instr_count}, 128'd24);
      drain("t3_drain");

      // 4: prior pc then pc 0x20 repeated; halt after the 4th 0x20
      do_start();
      check("t4_ovf_clr", {127'd0, overflow}, 128'd0);
      run_cyc(32'h1C, 1'b1, 16'd0);
      for (int i = 1; i < 4; i++) run_cyc(32'h20, 1'b1, 16'(i));
      check("t4_not_yet", {127'd0, halted}, 128'd0);
      run_cyc(32'h20, 1'b1, 16'd4);
      check("t4_halt", {127'd0, halted}, 128'd1);
      check("t4_cnt", {111'd0, instr_count}, 128'd5);
      run_cyc(32'h20, 1'b0, 16'd5);
      run_cyc(32'h24, 1'b0, 16'd5);
      check("t4_no_more", {111'd0, instr_count}, 128'd5);
      drain("t4_drain");

      // 6: reset mid-RUN with five queued records
      trace_ready = 1'b0;
      do_start();
      for (int i = 0; i < 5; i++) run_cyc(32'h300 + 32'(i * 4), 1'b0, 16'(i));
      check("t6_pre_valid", {127'd0, trace_valid}, 128'd1);
      check("t6_pre_cnt", {111'd0, instr_count}, 128'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_valid", {127'd0, trace_valid}, 128'd0);
      check("t6_cnt", {111'd0, instr_count}, 128'd0);
      check("t6_data", {41'd0, trace_data}, 128'd0);
      tick();
      rst_n = 1'b1;
      trace_ready = 1'b1;
      for (int i = 0; i < 5; i++) run_cyc(32'h400 + 32'(i * 4), 1'b0, 16'd0);
      check("t6_idle_valid", {127'd0, trace_valid}, 128'd0);
      check("t6_idle_cnt", {111'd0, instr_count}, 128'd0);
      check("t6_sb_empty", {96'd0, 32'(sb_q.size())}, 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
